// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode type and opcode encodings used by the
// decoder-facing ALU and its sub-blocks.
package alu_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_ADD  = 3'b000;
  localparam opcode_t OP_SLL  = 3'b001;
  localparam opcode_t OP_SLT  = 3'b010;
  localparam opcode_t OP_SLTU = 3'b011;
  localparam opcode_t OP_XOR  = 3'b100;
  localparam opcode_t OP_SRL  = 3'b101;
  localparam opcode_t OP_OR   = 3'b110;
  localparam opcode_t OP_AND  = 3'b111;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for SLL / SRL / SRA. dir=0 shifts left,
// dir=1 shifts right; arith selects sign fill on right shifts only.
module alu_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [SHW-1:0]   i_amount,
  input  logic             i_dir,
  input  logic             i_arith,
  output logic [WIDTH-1:0] o_result
);

  logic signed [WIDTH-1:0] w_data_s;

  assign w_data_s = i_data;

  // Select shift direction and fill; left shifts ignore arith.
  always_comb begin
    o_result = i_data;
    if (!i_dir) begin
      o_result = i_data << i_amount;
    end else if (i_arith) begin
      o_result = w_data_s >>> i_amount;
    end else begin
      o_result = i_data >> i_amount;
    end
  end

endmodule

// File: rtl/alu.sv
// 32-bit integer ALU with registered result and branch compare flags.
// Everything is computed combinationally and captured on the rising edge,
// giving one cycle of latency at one operation per cycle.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  input  opcode_t          Opcode,
  input  logic             ALUSel,
  output logic [WIDTH-1:0] ALU_out,
  output logic             Zero,
  output logic             BGT,
  output logic             BLT
);

  localparam int SHW = $clog2(WIDTH);

  logic signed [WIDTH-1:0] w_a_s;
  logic signed [WIDTH-1:0] w_b_s;
  logic [WIDTH-1:0]        w_addsub;
  logic [WIDTH-1:0]        w_shift;
  logic                    w_lt_s;
  logic                    w_gt_s;
  logic                    w_lt_u;
  logic                    w_shift_arith;
  logic [WIDTH-1:0]        w_result;

  logic [WIDTH-1:0]        r_result;
  logic                    r_zero;
  logic                    r_bgt;
  logic                    r_blt;

  assign w_a_s = DataA;
  assign w_b_s = DataB;

  // Signed compares feed both SLT and the branch flags; the flags ignore
  // Opcode entirely so the branch unit can use them on any instruction.
  assign w_lt_s = (w_a_s < w_b_s);
  assign w_gt_s = (w_a_s > w_b_s);
  assign w_lt_u = (DataA < DataB);

  // Single adder path, subtract selected by ALUSel; wraps modulo 2^WIDTH.
  assign w_addsub = ALUSel ? (DataA - DataB) : (DataA + DataB);

  // Only the SRL slot honours ALUSel as the arithmetic-fill select.
  assign w_shift_arith = ALUSel && (Opcode == OP_SRL);

  alu_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shifter (
    .i_data   (DataA),
    .i_amount (DataB[SHW-1:0]),
    .i_dir    (Opcode != OP_SLL),
    .i_arith  (w_shift_arith),
    .o_result (w_shift)
  );

  // Result mux: every opcode maps to a defined value.
  always_comb begin
    w_result = '0;
    case (Opcode)
      OP_ADD:  w_result = w_addsub;
      OP_SLL:  w_result = w_shift;
      OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_lt_s};
      OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, w_lt_u};
      OP_XOR:  w_result = DataA ^ DataB;
      OP_SRL:  w_result = w_shift;
      OP_OR:   w_result = DataA | DataB;
      OP_AND:  w_result = DataA & DataB;
      default: w_result = '0;
    endcase
  end

  // Output register; reset clears result and all flags, including Zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_bgt    <= 1'b0;
      r_blt    <= 1'b0;
    end else begin
      r_result <= w_result;
      r_zero   <= (w_result == '0);
      r_bgt    <= w_gt_s;
      r_blt    <= w_lt_s;
    end
  end

  assign ALU_out = r_result;
  assign Zero    = r_zero;
  assign BGT     = r_bgt;
  assign BLT     = r_blt;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: expected results are queued when an
// operation is driven and compared when the registered output appears.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] DataA;
  logic [31:0] DataB;
  logic [2:0]  Opcode;
  logic        ALUSel;
  logic [31:0] ALU_out;
  logic        Zero;
  logic        BGT;
  logic        BLT;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        gt;
    logic        lt;
    string       tag;
  } exp_t;

  exp_t q[$];

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        sel;
    logic [31:0] res;
    logic        z;
    logic        gt;
    logic        lt;
    string       tag;
  } vec_t;

  vec_t vecs[$];

  alu #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .DataA   (DataA),
    .DataB   (DataB),
    .Opcode  (Opcode),
    .ALUSel  (ALUSel),
    .ALU_out (ALU_out),
    .Zero    (Zero),
    .BGT     (BGT),
    .BLT     (BLT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model built from bit-level loops and sign-flip compares.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] op, input logic sel,
                                output logic [31:0] res, output logic z,
                                output logic gt, output logic lt);
    logic [31:0] t;
    logic [31:0] af;
    logic [31:0] bf;
    int sh;
    af = a ^ 32'h8000_0000;
    bf = b ^ 32'h8000_0000;
    sh = int'(b[4:0]);
    t  = a;
    case (op)
      3'b000: t = sel ? (a + (~b) + 32'd1) : (a + b);
      3'b001: for (int i = 0; i < sh; i++) t = {t[30:0], 1'b0};
      3'b010: t = (af < bf) ? 32'd1 : 32'd0;
      3'b011: t = (a < b) ? 32'd1 : 32'd0;
      3'b100: t = a ^ b;
      3'b101: for (int i = 0; i < sh; i++) t = {(sel ? t[31] : 1'b0), t[31:1]};
      3'b110: t = a | b;
      default: t = a & b;
    endcase
    res = t;
    z   = (t == 32'd0);
    gt  = (af > bf);
    lt  = (af < bf);
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic sel, input exp_t e);
    @(negedge clk);
    DataA  = a;
    DataB  = b;
    Opcode = op;
    ALUSel = sel;
    q.push_back(e);
  endtask

  task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic sel, input logic [31:0] res, input logic z,
                         input logic gt, input logic lt, input string tag);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.sel = sel;
    v.res = res; v.z = z; v.gt = gt; v.lt = lt; v.tag = tag;
    vecs.push_back(v);
  endtask

  // Monitor: one edge after each driven op, pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        chk({e.tag, ".out"}, ALU_out, e.res);
        chk({e.tag, ".zero"}, {31'd0, Zero}, {31'd0, e.z});
        chk({e.tag, ".bgt"}, {31'd0, BGT}, {31'd0, e.gt});
        chk({e.tag, ".blt"}, {31'd0, BLT}, {31'd0, e.lt});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    logic [31:0] a, b, r;
    logic [2:0]  op;
    logic        sel, z, gt, lt;

    rst_n  = 1'b0;
    DataA  = 32'd0;
    DataB  = 32'd0;
    Opcode = 3'd0;
    ALUSel = 1'b0;

    #2;
    chk("rst.out", ALU_out, 32'd0);
    chk("rst.zero", {31'd0, Zero}, 32'd0);
    chk("rst.bgt", {31'd0, BGT}, 32'd0);
    chk("rst.blt", {31'd0, BLT}, 32'd0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    add_vec(40, 2, 3'b000, 0, 42, 0, 1, 0, "add40");
    add_vec(40, 2, 3'b000, 1, 38, 0, 1, 0, "sub40");
    add_vec(40, 2, 3'b001, 0, 160, 0, 1, 0, "sll40");
    add_vec(40, 2, 3'b010, 0, 0, 1, 1, 0, "slt40");
    add_vec(40, 2, 3'b011, 0, 0, 1, 1, 0, "sltu40");
    add_vec(40, 2, 3'b100, 0, 42, 0, 1, 0, "xor40");
    add_vec(40, 2, 3'b101, 0, 10, 0, 1, 0, "srl40");
    add_vec(40, 2, 3'b101, 1, 10, 0, 1, 0, "sra40");
    add_vec(40, 2, 3'b110, 0, 42, 0, 1, 0, "or40");
    add_vec(40, 2, 3'b111, 0, 0, 1, 1, 0, "and40");
    add_vec(32'hFFFF_FFF0, 4, 3'b101, 0, 32'h0FFF_FFFF, 0, 0, 1, "srl_neg");
    add_vec(32'hFFFF_FFF0, 4, 3'b101, 1, 32'hFFFF_FFFF, 0, 0, 1, "sra_neg");
    add_vec(32'hFFFF_FFF0, 4, 3'b010, 0, 1, 0, 0, 1, "slt_neg");
    add_vec(32'hFFFF_FFF0, 4, 3'b011, 0, 0, 1, 0, 1, "sltu_neg");
    add_vec(32'hFFFF_FFFF, 1, 3'b000, 0, 0, 1, 0, 1, "add_wrap");
    add_vec(0, 1, 3'b000, 1, 32'hFFFF_FFFF, 0, 0, 1, "sub_wrap");
    add_vec(1, 32'h21, 3'b001, 0, 2, 0, 0, 1, "sll_mask");
    add_vec(7, 7, 3'b000, 1, 0, 1, 0, 0, "sub_eq");
    add_vec(32'h8000_0001, 0, 3'b101, 1, 32'h8000_0001, 0, 0, 1, "sra_zero_amt");
    add_vec(32'h8000_0000, 32'h7FFF_FFFF, 3'b011, 0, 0, 1, 0, 1, "sltu_vs_slt");

    foreach (vecs[i]) begin
      e.res = vecs[i].res; e.z = vecs[i].z; e.gt = vecs[i].gt; e.lt = vecs[i].lt;
      e.tag = vecs[i].tag;
      drive(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].sel, e);
    end

    // Back-to-back random operations, one per cycle.
    for (int i = 0; i < 300; i++) begin
      a   = $urandom;
      b   = (i % 4 == 0) ? a : ((i % 4 == 1) ? 32'($urandom_range(0, 40)) : $urandom);
      op  = 3'($urandom_range(0, 7));
      sel = 1'($urandom_range(0, 1));
      model(a, b, op, sel, r, z, gt, lt);
      e.res = r; e.z = z; e.gt = gt; e.lt = lt;
      e.tag = $sformatf("rnd%0d_op%0d_s%0d", i, op, sel);
      drive(a, b, op, sel, e);
    end

    // Reset mid-stream: outputs clear before the next edge, in-flight op lost.
    e.res = 42; e.z = 0; e.gt = 1; e.lt = 0; e.tag = "pre_rst_or";
    drive(40, 2, 3'b110, 0, e);
    @(negedge clk);
    DataA = 5; DataB = 3; Opcode = 3'b000; ALUSel = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.out", ALU_out, 32'd0);
    chk("midrst.zero", {31'd0, Zero}, 32'd0);
    chk("midrst.bgt", {31'd0, BGT}, 32'd0);
    chk("midrst.blt", {31'd0, BLT}, 32'd0);
    @(posedge clk);
    #1;
    chk("held_rst.out", ALU_out, 32'd0);
    chk("held_rst.bgt", {31'd0, BGT}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    DataA = 40; DataB = 2; Opcode = 3'b000; ALUSel = 1'b1;
    #1;
    chk("post_rel.out", ALU_out, 32'd0);
    chk("post_rel.zero", {31'd0, Zero}, 32'd0);
    e.res = 38; e.z = 0; e.gt = 1; e.lt = 0; e.tag = "first_after_rst";
    q.push_back(e);

    // Input changes between edges must not reach the outputs.
    @(posedge clk);
    #3;
    DataA = 32'd0;
    DataB = 32'd0;
    #1;
    chk("hold.out", ALU_out, 32'd38);
    chk("hold.zero", {31'd0, Zero}, 32'd0);

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
